// File: rtl/merge_sched.sv
// merge_sched: round-robin arbiter for two requesters feeding a shared 2-stage pass/add pipeline
module merge_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic [CNT_W-1:0] inflight
);
  typedef enum logic {PRI0, PRI1} pri_t;
  pri_t             pri;
  logic             s1_valid, s1_sel, s1_id, s2_valid;
  logic             s1_take, s2_take, grant;
  logic [WIDTH-1:0] s1_a, s1_b;
  assign s2_take    = !s2_valid | out_ready;
  assign s1_take    = !s1_valid | s2_take;
  assign req0_ready = s1_take & req0_valid & (!req1_valid | pri == PRI0);
  assign req1_ready = s1_take & req1_valid & (!req0_valid | pri == PRI1);
  assign grant      = req0_ready | req1_ready;
  assign out_valid  = s2_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pri      <= PRI0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= 1'b0;
      s1_id    <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_id   <= 1'b0;
      inflight <= '0;
    end else begin
      if (grant) pri <= req0_ready ? PRI1 : PRI0;
      if (s1_take) s1_valid <= grant;
      if (grant) begin
        s1_a   <= req0_ready ? req0_a : req1_a;
        s1_b   <= req0_ready ? req0_b : req1_b;
        s1_sel <= req0_ready ? req0_sel : req1_sel;
        s1_id  <= req1_ready;
      end
      if (s2_take) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_sel ? s1_a : s1_a + s1_b;
          out_id   <= s1_id;
        end
      end
      inflight <= inflight + CNT_W'(grant) - CNT_W'(s2_valid & out_ready);
    end
endmodule

// File: tb/tb_merge_sched.sv
// tb_merge_sched: randomized scoreboard bench for merge_sched with a capacity/round-robin reference model
module tb_merge_sched;
  logic       clk = 0, rst = 1;
  logic       req0_valid = 0, req0_sel = 0, req1_valid = 0, req1_sel = 0, out_ready = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       req0_ready, req1_ready, out_valid, out_id;
  logic [7:0] out_data;
  logic [1:0] inflight;

  merge_sched #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int id; int t; } exp_t;
  exp_t q[$];
  int   checks = 0, errors = 0, cyc = 0, mcnt = 0, fav = 0;
  logic took0 = 0, took1 = 0, pstall = 0, pid = 0;
  logic [7:0] pd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: pipeline holds at most 2 ops; a full pipeline with a blocked sink admits nothing.
  always @(negedge clk) if (!rst) begin
    bit take, e0, e1;
    take = !(mcnt == 2 && !out_ready);
    e0 = take && req0_valid && (!req1_valid || fav == 0);
    e1 = take && req1_valid && (!req0_valid || fav == 1);
    chk("ready0", int'(req0_ready), int'(e0));
    chk("ready1", int'(req1_ready), int'(e1));
    chk("inflight", int'(inflight), mcnt);
    took0 = req0_ready;
    took1 = req1_ready;
    if (e0 || e1) begin
      int a, b, s;
      a = e0 ? int'(req0_a) : int'(req1_a);
      b = e0 ? int'(req0_b) : int'(req1_b);
      s = e0 ? int'(req0_sel) : int'(req1_sel);
      q.push_back('{d: s ? a : (a + b) % 256, id: e1 ? 1 : 0, t: cyc});
      fav = e0 ? 1 : 0;
      mcnt++;
    end
    if (out_valid && out_ready) mcnt--;
  end

  always @(negedge clk) begin
    if (rst) pstall = 0;
    else begin
      if (pstall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(pd));
        chk("stall_id", int'(out_id), int'(pid));
      end
      if (q.size() > 0 && cyc >= q[0].t + 2) chk("latency_valid", int'(out_valid), 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", int'(out_data), e.d);
          chk("out_id", int'(out_id), e.id);
        end
      end
      pstall = out_valid && !out_ready;
      pd = out_data;
      pid = out_id;
    end
  end

  task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic s0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic s1,
                       input logic ordy);
    @(posedge clk); #1;
    if (!(req0_valid && !took0)) begin req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0; end
    if (!(req1_valid && !took1)) begin req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1; end
    out_ready = ordy;
  endtask

  task automatic idle(input int n, input logic ordy);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_inflight", int'(inflight), 0);
    rst = 0;
    drive(1, 3, 4, 0, 0, 0, 0, 0, 1);
    idle(4, 1);
    for (int i = 0; i < 4; i++) drive(1, 8'(10 + i), 1, 0, 1, 8'(20 + i), 2, 0, 1);
    idle(3, 1);
    drive(1, 8'hF0, 8'h20, 0, 0, 0, 0, 0, 1);
    drive(1, 8'hAB, 8'hFF, 1, 0, 0, 0, 0, 1);
    idle(3, 1);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 2, 2, 0, 1);
    repeat (5) drive(1, 7, 7, 0, 1, 9, 9, 1, 0);
    repeat (3) drive(1, 7, 7, 0, 1, 9, 9, 1, 1);
    idle(4, 1);
    drive(1, 5, 6, 0, 1, 7, 8, 0, 0);
    drive(1, 5, 6, 0, 1, 7, 8, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    chk("pre_rst_inflight", int'(inflight), 2);
    rst = 1;
    req0_valid = 0;
    req1_valid = 0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_inflight", int'(inflight), 0);
    q.delete();
    mcnt = 0;
    fav = 0;
    took0 = 0;
    took1 = 0;
    @(posedge clk); #1;
    rst = 0;
    idle(3, 1);
    repeat (3) drive(1, 8'h11, 8'h22, 0, 1, 8'h33, 8'h44, 1, 1);
    idle(3, 1);
    for (int i = 0; i < 12; i++)
      drive(0, 0, 0, 0, 1, 8'($urandom), 8'($urandom), 1'($urandom), 1);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 7);
    idle(10, 1);
    chk("drain_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
